// File: rtl/rv_pkg.sv
// Shared RV32 constants and fetch-queue entry layout.
package rv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST    = 32'h0000_0013;
   localparam logic [XLEN-1:0] EBREAK_INST = 32'h0010_0073;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_HALT  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {inst, pc, pc+4} entries; flush resets the pointers.
module fetch_fifo
   import rv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // a full queue still accepts a write when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between the shared memory port and IF/ID.
//   state    | meaning
//   ST_FETCH | issuing fetches while queue + in-flight slot has room
//   ST_HALT  | EBREAK enqueued; no fetches, queue drains, left by redirect
module fetch_buffer
   import rv_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pc4,
   output logic        halted
);

   localparam int AW = $clog2(DEPTH);

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   fpc_q, fpc_d;
   logic          inflight_q, inflight_d;
   logic          drop_q, drop_d;
   logic          req_q, req_d;
   logic          grant, push, pop;
   logic          fifo_full, fifo_empty;
   logic [AW:0]   count, count_nxt;
   logic [AW+1:0] occ_nxt;
   logic [ENTRY_W-1:0] fifo_dout;
   fetch_entry_t  head, new_entry;
   logic          unused_bits;

   assign unused_bits = ^{redirect_pc[1:0], fifo_full};

   // request is registered so it is low out of reset; redirect still kills it combinationally
   assign fetch_req  = req_q && !redirect;
   assign fetch_addr = pc_q;
   assign halted     = (state_q == ST_HALT);
   assign grant      = fetch_req && fetch_gnt;
   assign push       = mem_rvalid && !drop_q && !redirect && (state_q == ST_FETCH);
   assign pop        = !fifo_empty && inst_ready;

   assign new_entry.inst = mem_rdata;
   assign new_entry.pc   = fpc_q;
   assign new_entry.pc4  = fpc_q + 32'd4;

   assign head       = fetch_entry_t'(fifo_dout);
   assign inst_valid = !fifo_empty;
   assign inst       = fifo_empty ? NOP_INST : head.inst;
   assign inst_pc    = fifo_empty ? 32'h0 : head.pc;
   assign inst_pc4   = fifo_empty ? 32'h0 : head.pc4;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .din   (new_entry),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fpc_d      = fpc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      if (mem_rvalid) begin
         inflight_d = 1'b0;
         drop_d     = 1'b0;
      end
      if (grant) begin
         pc_d       = pc_q + 32'd4;
         fpc_d      = pc_q;
         inflight_d = 1'b1;
      end
      if (push && (mem_rdata == EBREAK_INST)) state_d = ST_HALT;
      if (redirect) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         state_d = ST_FETCH;
         // a response landing in this cycle is already discarded; only later ones need dropping
         drop_d  = (inflight_q && !mem_rvalid) || grant;
      end
      count_nxt = redirect ? '0 : (count + (AW+1)'(push) - (AW+1)'(pop));
      occ_nxt   = {1'b0, count_nxt} + (AW+2)'(inflight_d);
      req_d     = (state_d == ST_FETCH) && (occ_nxt < (AW+2)'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         fpc_q      <= RESET_PC;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fpc_q      <= fpc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         req_q      <= req_d;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_buffer;
   import rv_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NO_BRK   = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fetch_req, fetch_gnt, mem_rvalid, redirect, inst_valid, inst_ready, halted;
   logic [31:0] fetch_addr, mem_rdata, redirect_pc, inst, inst_pc, inst_pc4;

   always #5 clk = ~clk;

   fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_gnt(fetch_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
      .halted(halted)
   );

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc, m_fpc, ebreak_addr, pend_addr;
   bit          m_inflight, m_halt, m_started, pend_valid;
   int          n_vec, n_err, cyc;
   logic [130:0] obs, expv;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == ebreak_addr) ? EBREAK_INST : a + 32'h100;
   endfunction

   function automatic bit exp_req();
      return m_started && !m_halt && ((mq.size() + int'(m_inflight)) < DEPTH) && !redirect;
   endfunction

   function automatic logic [130:0] model_exp();
      ent_t h;
      h = '0;
      if (mq.size() > 0) h = mq[0];
      else h.inst = NOP_INST;
      return {exp_req(), m_pc, (mq.size() > 0), h.inst, h.pc, h.pc4, m_halt};
   endfunction

   function automatic logic [130:0] dut_bus();
      return {fetch_req, fetch_addr, inst_valid, inst, inst_pc, inst_pc4, halted};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pc = RESET_PC; m_fpc = RESET_PC;
      m_inflight = 0; m_halt = 0; m_started = 0; pend_valid = 0; pend_addr = 0;
   endtask

   task automatic drive(input bit g, input bit r, input bit rd, input logic [31:0] rpc);
      fetch_gnt   = g;
      inst_ready  = r;
      redirect    = rd;
      redirect_pc = rpc;
      mem_rvalid  = pend_valid;
      mem_rdata   = pend_valid ? mem_word(pend_addr) : 32'h0;
      #1;
   endtask

   task automatic advance();
      bit req, grant, pop, hit;
      ent_t e;
      req   = exp_req();
      grant = req && fetch_gnt;
      pop   = (mq.size() > 0) && inst_ready;
      hit   = 0;
      if (redirect) begin
         mq.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
         m_halt = 0;
         m_inflight = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_inflight && !m_halt) begin
            e.inst = mem_word(m_fpc); e.pc = m_fpc; e.pc4 = m_fpc + 32'd4;
            mq.push_back(e);
            hit = (e.inst == EBREAK_INST);
         end
         if (grant) begin
            m_fpc = m_pc;
            m_pc  = m_pc + 32'd4;
         end
         m_inflight = grant;
         if (hit) m_halt = 1;
      end
      m_started  = 1;
      pend_valid = (fetch_req === 1'b1) && (fetch_gnt === 1'b1);
      pend_addr  = fetch_addr;
      cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1, 1, 0, 32'h0);
      @(negedge clk);
      obs = dut_bus();
      n_vec++;
      if (obs !== {1'b0, RESET_PC, 1'b0, NOP_INST, 32'h0, 32'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_outputs got=%h exp=%h", obs, {1'b0, RESET_PC, 1'b0, NOP_INST, 32'h0, 32'h0, 1'b0});
      end
      @(negedge clk);
      model_reset();
      rst = 1'b1;
   endtask

   task automatic test_stream();
      int first_gnt, first_val;
      first_gnt = -1; first_val = -1;
      for (int i = 0; i < 14; i++) begin
         drive(1, 1, 0, 32'h0);
         obs = dut_bus(); expv = model_exp(); n_vec++;
         if (obs !== expv) begin
            n_err++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         if (first_gnt < 0 && fetch_req === 1'b1) first_gnt = i;
         if (first_val < 0 && inst_valid === 1'b1) first_val = i;
         advance();
      end
      n_vec++;
      if (first_gnt < 0 || first_val < 0 || (first_val - first_gnt) != 2) begin
         n_err++; $display("FAIL stream_latency got=%0d exp=2", first_val - first_gnt);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 0, 32'h0);
         obs = dut_bus(); expv = model_exp(); n_vec++;
         if (obs !== expv) begin
            n_err++; $display("FAIL full_fill cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         advance();
      end
      drive(1, 0, 0, 32'h0);
      n_vec++;
      if ({inst_valid, fetch_req} !== 2'b10) begin
         n_err++; $display("FAIL full_stall got=%b exp=10", {inst_valid, fetch_req});
      end
      advance();
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 0, 32'h0);
         obs = dut_bus(); expv = model_exp(); n_vec++;
         if (obs !== expv) begin
            n_err++; $display("FAIL full_drain cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         advance();
      end
   endtask

   task automatic test_gnt_stall();
      logic [31:0] saved;
      saved = m_pc;
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 0, 32'h0);
         obs = dut_bus(); expv = model_exp(); n_vec++;
         if (obs !== expv) begin
            n_err++; $display("FAIL gnt_stall cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         n_vec++;
         if (fetch_addr !== saved) begin
            n_err++; $display("FAIL gnt_hold got=%h exp=%h", fetch_addr, saved);
         end
         advance();
      end
      drive(1, 1, 0, 32'h0);
      n_vec++;
      if ({fetch_req, fetch_addr} !== {1'b1, saved}) begin
         n_err++; $display("FAIL gnt_resume got=%h exp=%h", {fetch_req, fetch_addr}, {1'b1, saved});
      end
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 32'h0);
         obs = dut_bus(); expv = model_exp(); n_vec++;
         if (obs !== expv) begin
            n_err++; $display("FAIL gnt_after cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         advance();
      end
   endtask

   task automatic test_redirect();
      drive(0, 0, 1, 32'h10); advance();
      drive(1, 0, 0, 32'h0);
      n_vec++;
      if ({fetch_req, fetch_addr} !== {1'b1, 32'h10}) begin
         n_err++; $display("FAIL redir_setup got=%h exp=%h", {fetch_req, fetch_addr}, {1'b1, 32'h10});
      end
      advance();
      drive(1, 0, 1, 32'h41);
      obs = dut_bus(); expv = model_exp(); n_vec++;
      if (obs !== expv) begin
         n_err++; $display("FAIL redir_cycle got=%h exp=%h", obs, expv);
      end
      advance();
      drive(1, 0, 0, 32'h0);
      n_vec++;
      if ({inst_valid, fetch_req, fetch_addr} !== {1'b0, 1'b1, 32'h40}) begin
         n_err++; $display("FAIL redir_flush got=%h exp=%h", {inst_valid, fetch_req, fetch_addr}, {1'b0, 1'b1, 32'h40});
      end
      advance();
      drive(0, 0, 0, 32'h0); advance();
      drive(0, 0, 0, 32'h0);
      n_vec++;
      if ({inst_valid, inst_pc, inst_pc4, inst} !== {1'b1, 32'h40, 32'h44, 32'h140}) begin
         n_err++; $display("FAIL redir_head got=%h exp=%h", {inst_valid, inst_pc, inst_pc4, inst}, {1'b1, 32'h40, 32'h44, 32'h140});
      end
      obs = dut_bus(); expv = model_exp(); n_vec++;
      if (obs !== expv) begin
         n_err++; $display("FAIL redir_model got=%h exp=%h", obs, expv);
      end
      advance();
   endtask

   task automatic test_ebreak();
      bit seen;
      seen = 0;
      ebreak_addr = 32'h8;
      drive(0, 1, 1, 32'h0); advance();
      for (int i = 0; i < 9; i++) begin
         drive(1, 1, 0, 32'h0);
         obs = dut_bus(); expv = model_exp(); n_vec++;
         if (obs !== expv) begin
            n_err++; $display("FAIL ebreak_run cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         if (inst_valid === 1'b1 && inst_pc === 32'h8 && inst === EBREAK_INST) seen = 1;
         advance();
      end
      drive(1, 1, 0, 32'h0);
      n_vec++;
      if ({seen, halted, fetch_req, inst_valid} !== 4'b1100) begin
         n_err++; $display("FAIL ebreak_halt got=%b exp=1100", {seen, halted, fetch_req, inst_valid});
      end
      advance();
      ebreak_addr = NO_BRK;
      drive(1, 1, 1, 32'h0); advance();
      drive(1, 1, 0, 32'h0);
      n_vec++;
      if ({halted, fetch_req, fetch_addr} !== {1'b0, 1'b1, 32'h0}) begin
         n_err++; $display("FAIL ebreak_resume got=%h exp=%h", {halted, fetch_req, fetch_addr}, {1'b0, 1'b1, 32'h0});
      end
      advance();
   endtask

   task automatic test_random();
      bit g, r, rd;
      logic [31:0] rpc;
      ebreak_addr = 32'h40;
      for (int i = 0; i < 400; i++) begin
         g  = ($urandom_range(0, 9) < 7);
         r  = ($urandom_range(0, 9) < 7);
         rd = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else rpc = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
         drive(g, r, rd, rpc);
         obs = dut_bus(); expv = model_exp(); n_vec++;
         if (obs !== expv) begin
            n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         advance();
      end
      ebreak_addr = NO_BRK;
   endtask

   task automatic test_async_reset();
      drive(0, 1, 1, 32'h80); advance();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 32'h0); advance();
      end
      drive(1, 0, 0, 32'h0);
      #2 rst = 1'b0;
      #1;
      model_reset();
      obs = dut_bus(); n_vec++;
      if (obs !== {1'b0, RESET_PC, 1'b0, NOP_INST, 32'h0, 32'h0, 1'b0}) begin
         n_err++;
         $display("FAIL async_reset got=%h exp=%h", obs, {1'b0, RESET_PC, 1'b0, NOP_INST, 32'h0, 32'h0, 1'b0});
      end
      @(negedge clk);
      drive(1, 1, 0, 32'h0);
      #1 rst = 1'b1;
      #1;
      obs = dut_bus(); expv = model_exp(); n_vec++;
      if (obs !== expv) begin
         n_err++; $display("FAIL async_release got=%h exp=%h", obs, expv);
      end
      advance();
      drive(1, 1, 0, 32'h0);
      n_vec++;
      if ({fetch_req, fetch_addr} !== {1'b1, RESET_PC}) begin
         n_err++; $display("FAIL async_first got=%h exp=%h", {fetch_req, fetch_addr}, {1'b1, RESET_PC});
      end
      advance();
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 0, 32'h0);
         obs = dut_bus(); expv = model_exp(); n_vec++;
         if (obs !== expv) begin
            n_err++; $display("FAIL async_after cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         advance();
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      fetch_gnt = 0; inst_ready = 0; redirect = 0; redirect_pc = 0;
      mem_rvalid = 0; mem_rdata = 0;
      ebreak_addr = NO_BRK;
      model_reset();
      test_reset();
      test_stream();
      test_full();
      test_gnt_stall();
      test_redirect();
      test_ebreak();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction prefetch stage between the unified single-port instruction/data memory and the IF/ID pipeline register.
- Issues word fetches when the data port leaves the memory idle, and queues returned instructions with their PC and PC+4.
- Presents queued instructions to IF/ID through a valid/ready handshake.
- Flushes on branch/jump redirect from MEM; stops fetching once EBREAK is enqueued.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_req  out  1  fetch request to the memory arbiter.
- fetch_addr  out  32  word address of the fetch; bits [1:0] always 0.
- fetch_gnt  in  1  arbiter accepts the request this cycle; data accesses have priority.
- mem_rvalid  in  1  read data for the oldest granted fetch is valid, exactly 1 cycle after grant.
- mem_rdata  in  32  instruction word.
- redirect  in  1  taken branch/jump from MEM stage.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored.
- inst_valid  out  1  head entry valid.
- inst_ready  in  1  IF/ID accepts the head entry (low means stall).
- inst  out  32  head instruction; 32'h0000_0013 (NOP) when empty.
- inst_pc  out  32  PC of the head instruction.
- inst_pc4  out  32  inst_pc + 4, for JAL/JALR link.
- halted  out  1  EBREAK enqueued; fetching stopped.

Behaviour:
Reset (rst=0, async):
- Queue empty; pc = RESET_PC.
- inst_valid=0, inst=NOP, inst_pc=0, inst_pc4=0.
- fetch_req=0, fetch_addr=RESET_PC, halted=0; in-flight and drop flags cleared.

FSM states:
- FETCH: fetch_req = (count + inflight < DEPTH) && !redirect. fetch_addr = pc.
  - On fetch_gnt: pc <= pc + 4 (wraps modulo 2^32); inflight <= 1.
- HALT: fetch_req=0 and halted=1. Entered the cycle after an EBREAK (32'h0010_0073) is enqueued.
  - Queue still drains normally.
  - Left only by redirect (to FETCH) or reset.

Other rules:
- Only one fetch may be outstanding. A new grant is possible in the same cycle a response returns, since the slot frees.
- Responses: on mem_rvalid with drop=0, push {mem_rdata, pc_of_fetch, pc_of_fetch+4}. With drop=1, discard the data and clear drop.
- Pop: the head is popped when inst_valid && inst_ready. Push and pop in the same cycle are legal when full or empty; count is unchanged when both happen.
- Redirect (priority over everything except reset):
  - Queue cleared next cycle; any pop in that cycle has already occurred.
  - pc <= {redirect_pc[31:2], 2'b00}; state returns to FETCH.
  - If a fetch is in flight or granted this cycle, drop <= 1.
  - A response arriving in the redirect cycle itself is discarded.
  - fetch_req=0 in the redirect cycle; the first new request is the following cycle.
- Full: no request is issued while count + inflight == DEPTH. Overflow is impossible by construction.
- Read and write pointers are log2(DEPTH) bits and wrap; count is log2(DEPTH)+1 bits.
- Latency:
  - Grant at cycle N gives data at N+1.
  - inst_valid at N+2 if the queue was empty, since outputs come from a registered head.
  - Steady-state throughput is 1 instruction/cycle when grants are continuous.

Decomposition:
- rv_pkg: constants NOP_INST=32'h0000_0013, EBREAK_INST=32'h0010_0073, XLEN=32.
- One sub-module, fetch_fifo: synchronous FIFO, width 96, DEPTH entries.
  - Ports: push/pop/flush, full/empty/count.
  - Flush clears the pointers.

Test Plan:
1. Release reset with fetch_gnt=1 and memory returning addr+0x100, inst_ready=1 -> fetch_addr 0,4,8,...; inst_pc 0,4,8 with inst 0x100,0x104,...; first inst_valid 2 cycles after first grant.
2. inst_ready=0 with continuous grants -> exactly DEPTH=4 entries queued, fetch_req drops to 0, no overflow. Raise inst_ready -> entries drain in order and fetching resumes.
3. fetch_gnt=0 for 5 cycles (data port busy) -> fetch_addr held and no entries enqueued; on grant, the fetch resumes at the held address.
4. Redirect to 0x40 while a fetch to 0x10 is in flight -> the 0x10 response is dropped, the queue is empty next cycle, the next fetch_addr is 0x40, and inst_pc=0x40 / inst_pc4=0x44.
5. EBREAK returned at PC 0x8 -> halted=1 and fetch_req=0; queue drains through 0x8. Redirect to 0x0 -> halted=0 and fetching restarts at 0x0.
6. Assert rst=0 mid-stream (asynchronously, between edges) -> outputs reach reset values immediately; after release, the first fetch is at RESET_PC.
